// File: rtl/gfe_pkg.sv
// Shared definitions for the GF(P) inverse lookup block.
package gfe_pkg;

  localparam int GFE_P_DEF   = 3;
  localparam int GFE_NCH_DEF = 2;

  // Init FSM states: build the table, then serve lookups.
  typedef enum logic [0:0] {
    FILL = 1'b0,
    DONE = 1'b1
  } gfe_state_e;

  // Element width: ceil(log2(p)), never narrower than one bit.
  function automatic int gfe_width(input int p);
    int w;
    w = $clog2(p);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/gfe_inv_tab_init.sv
// Run-time builder for the GF(P) inverse table. For each a it walks b
// upward while accumulating a*b mod P by repeated addition; when the
// accumulator reaches 1, b is the inverse of a and is written out.
module gfe_inv_tab_init
  import gfe_pkg::*;
#(
  parameter int P = GFE_P_DEF,
  parameter int W = gfe_width(P)
) (
  input  logic         clk,
  input  logic         rst,
  output logic         we,
  output logic [W-1:0] waddr,
  output logic [W-1:0] wdata,
  output logic         init_done
);

  localparam logic [W-1:0] ONE    = W'(1);
  localparam logic [W-1:0] A_LAST = W'(P - 1);
  localparam logic [W:0]   P_EXT  = (W + 1)'(P);

  gfe_state_e     state_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [W-1:0]   acc_q;
  logic [W:0]     acc_sum_s;
  logic [W-1:0]   acc_d;

  // Next accumulator value a*(b+1) mod P, using one add and one conditional subtract.
  always_comb begin
    acc_sum_s = {1'b0, acc_q} + {1'b0, a_q};
    if (acc_sum_s >= P_EXT) begin
      acc_d = W'(acc_sum_s - P_EXT);
    end else begin
      acc_d = W'(acc_sum_s);
    end
  end

  // Init FSM: one search step per clock until the last element is resolved.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      a_q     <= ONE;
      b_q     <= ONE;
      acc_q   <= ONE;
    end else begin
      case (state_q)
        FILL: begin
          if (acc_q == ONE) begin
            if (a_q == A_LAST) begin
              state_q <= DONE;
            end else begin
              a_q   <= a_q + ONE;
              b_q   <= ONE;
              acc_q <= a_q + ONE;
            end
          end else begin
            b_q   <= b_q + ONE;
            acc_q <= acc_d;
          end
        end
        DONE:    state_q <= DONE;
        default: state_q <= FILL;
      endcase
    end
  end

  // A write fires on the step that finds the inverse; the final write and
  // the move to DONE share the same edge, so init_done rises with it.
  assign we        = (state_q == FILL) && (acc_q == ONE);
  assign waddr     = a_q;
  assign wdata     = b_q;
  assign init_done = (state_q == DONE);

endmodule

// File: rtl/gfe_inv_p.sv
// Multi-channel GF(P) inverse lookup. The table is built at run time by
// gfe_inv_tab_init; afterwards every channel reads it in parallel with a
// one-cycle registered result. Entry 0 is never written and never read.
module gfe_inv_p
  import gfe_pkg::*;
#(
  parameter int  P   = GFE_P_DEF,
  parameter int  NCH = GFE_NCH_DEF,
  localparam int W   = gfe_width(P)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   din_valid,
  input  logic [NCH*W-1:0] din,
  output logic             init_done,
  output logic [NCH-1:0]   dout_valid,
  output logic [NCH*W-1:0] dout,
  output logic [NCH-1:0]   dout_en
);

  localparam logic [W:0] P_EXT = (W + 1)'(P);

  logic [W-1:0]     tab_q [P];
  logic             tab_we_s;
  logic [W-1:0]     tab_waddr_s;
  logic [W-1:0]     tab_wdata_s;
  logic             init_done_s;

  logic [NCH-1:0]   dout_valid_d;
  logic [NCH-1:0]   dout_en_d;
  logic [NCH*W-1:0] dout_d;
  logic [NCH-1:0]   dout_valid_q;
  logic [NCH-1:0]   dout_en_q;
  logic [NCH*W-1:0] dout_q;

  gfe_inv_tab_init #(
    .P (P),
    .W (W)
  ) u_tab_init (
    .clk       (clk),
    .rst       (rst),
    .we        (tab_we_s),
    .waddr     (tab_waddr_s),
    .wdata     (tab_wdata_s),
    .init_done (init_done_s)
  );

  // Table storage; contents survive reset and are fully rewritten by FILL.
  always_ff @(posedge clk) begin
    if (tab_we_s) begin
      tab_q[tab_waddr_s] <= tab_wdata_s;
    end
  end

  // Per-channel lookup; inputs before init_done are dropped, out-of-range
  // elements (0 or >= P) report a valid result with no inverse.
  always_comb begin
    dout_valid_d = '0;
    dout_en_d    = '0;
    dout_d       = '0;
    for (int i = 0; i < NCH; i++) begin
      logic [W-1:0] x;
      x = din[i*W +: W];
      if (init_done_s && din_valid[i]) begin
        dout_valid_d[i] = 1'b1;
        if ((x != '0) && ({1'b0, x} < P_EXT)) begin
          dout_en_d[i]       = 1'b1;
          dout_d[i*W +: W]   = tab_q[x];
        end else begin
          dout_en_d[i]       = 1'b0;
          dout_d[i*W +: W]   = '0;
        end
      end else begin
        dout_valid_d[i] = 1'b0;
      end
    end
  end

  // Result registers; reset clears any result in flight immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_valid_q <= '0;
      dout_en_q    <= '0;
      dout_q       <= '0;
    end else begin
      dout_valid_q <= dout_valid_d;
      dout_en_q    <= dout_en_d;
      dout_q       <= dout_d;
    end
  end

  assign init_done  = init_done_s;
  assign dout_valid = dout_valid_q;
  assign dout_en    = dout_en_q;
  assign dout       = dout_q;

endmodule

// File: tb/tb_gfe_inv_p.sv
// Scoreboard bench for gfe_inv_p: three configurations (P=5/NCH=2,
// P=3/NCH=2, P=7/NCH=4) run side by side. Expected results come from a
// brute-force modular-inverse model and an edge count since reset release.
module tb_gfe_inv_p;
  import gfe_pkg::*;

  typedef struct {
    int   due;
    int   ch;
    int   x;
    int   d;
    logic en;
  } ent_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Inverse by exhaustive search; 0 when x has no inverse in GF(p).
  function automatic int inv_of(input int p, input int x);
    if (x < 1 || x >= p) return 0;
    for (int y = 1; y < p; y++) begin
      if ((x * y) % p == 1) return y;
    end
    return 0;
  endfunction

  // Table build time: one step per candidate tried for each element.
  function automatic int fill_cycles(input int p);
    int s;
    s = 0;
    for (int a = 1; a < p; a++) s += inv_of(p, a);
    return s;
  endfunction

  task automatic chk(input int g, input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL cfg%0d %s actual=%0d expected=%0d (cycle %0d)", g, nm, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : gcfg
    localparam int PP = (g == 0) ? 5 : ((g == 1) ? 3 : 7);
    localparam int NN = (g == 2) ? 4 : 2;
    localparam int WW = gfe_width(PP);
    localparam int KN = (g == 2) ? 1100 : 400;
    localparam int SW = 60;
    localparam int RA = 200;

    logic             rst_g = 1'b1;
    logic [NN-1:0]    dv = '0;
    logic [NN*WW-1:0] din = '0;
    logic             idone;
    logic [NN-1:0]    ov;
    logic [NN*WW-1:0] od;
    logic [NN-1:0]    oe;

    int   n_edges = 0;
    int   fill_n = 0;
    bit   fin = 1'b0;
    ent_t q[$];

    logic [NN-1:0] ev;
    logic [NN-1:0] ee;
    int   ed [NN];
    int   ex [NN];
    ent_t e;

    gfe_inv_p #(
      .P   (PP),
      .NCH (NN)
    ) dut (
      .clk        (clk),
      .rst        (rst_g),
      .din_valid  (dv),
      .din        (din),
      .init_done  (idone),
      .dout_valid (ov),
      .dout       (od),
      .dout_en    (oe)
    );

    // Rising edges seen since reset was released.
    always @(posedge clk or posedge rst_g) begin
      if (rst_g) n_edges <= 0;
      else       n_edges <= n_edges + 1;
    end

    // Monitor: collect what is due this cycle and compare every channel.
    always @(negedge clk) begin
      ev = '0;
      ee = '0;
      for (int i = 0; i < NN; i++) begin
        ed[i] = 0;
        ex[i] = 0;
      end
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        ev[e.ch] = 1'b1;
        ee[e.ch] = e.en;
        ed[e.ch] = e.d;
        ex[e.ch] = e.x;
      end
      chk(g, "init_done", int'(idone), int'(!rst_g && (n_edges >= fill_n)));
      for (int i = 0; i < NN; i++) begin
        chk(g, "dout_valid", int'(ov[i]), int'(ev[i]));
        chk(g, "dout_en", int'(oe[i]), int'(ee[i]));
        chk(g, "dout", int'(od[i*WW +: WW]), ed[i]);
        if (ee[i] && oe[i]) begin
          chk(g, "x*dout mod p", (ex[i] * int'(od[i*WW +: WW])) % PP, 1);
        end
      end
    end

    // Stimulus: reset, early reset during FILL, sweep, random traffic, mid-stream reset.
    initial begin
      fill_n = fill_cycles(PP);
      repeat (2) @(posedge clk);
      #1;
      chk(g, "rst init_done", int'(idone), 0);
      chk(g, "rst dout_valid", int'(ov), 0);
      for (int k = 0; k < KN; k++) begin
        if (k == 0 || k == 6 || k == RA + 2) rst_g = 1'b0;
        if (k == 4 || k == RA) begin
          rst_g = 1'b1;
          #1;
          chk(g, "async init_done", int'(idone), 0);
          chk(g, "async dout_valid", int'(ov), 0);
          chk(g, "async dout_en", int'(oe), 0);
          chk(g, "async dout", int'(od), 0);
          q.delete();
        end
        if (k >= SW && k < SW + (1 << WW)) begin
          dv = '1;
          for (int i = 0; i < NN; i++) din[i*WW +: WW] = WW'((k - SW + i) % (1 << WW));
        end else begin
          dv = NN'($urandom);
          for (int i = 0; i < NN; i++) din[i*WW +: WW] = WW'($urandom_range(0, (1 << WW) - 1));
        end
        if (!rst_g && n_edges >= fill_n) begin
          for (int i = 0; i < NN; i++) begin
            if (dv[i]) begin
              ent_t ne;
              ne.due = cyc + 1;
              ne.ch  = i;
              ne.x   = int'(din[i*WW +: WW]);
              ne.d   = inv_of(PP, ne.x);
              ne.en  = (ne.d != 0);
              q.push_back(ne);
            end
          end
        end
        @(posedge clk);
        #1;
      end
      dv = '0;
      repeat (3) @(posedge clk);
      chk(g, "scoreboard drained", q.size(), 0);
      fin = 1'b1;
    end
  end

  // Wait for every configuration, bounded, then report.
  initial begin
    for (int t = 0; t < 50000; t++) begin
      if (gcfg[0].fin && gcfg[1].fin && gcfg[2].fin) break;
      @(posedge clk);
    end
    checks++;
    if (!(gcfg[0].fin && gcfg[1].fin && gcfg[2].fin)) begin
      failures++;
      $display("FAIL timeout actual=unfinished expected=finished");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
